mem_stage_ctrl: RTL and testbench

Memory-access stage and MEM/WB pipeline register of the ARM pipeline. It consumes the execute stage's result bundle: ALU result as address, Rm value as store data, memory enables and destination register. It performs loads and stores against an internal word-addressed data memory with a configurable wait-state latency. While an access is in flight it freezes the upstream pipeline, and it delivers a registered bundle to write-back.

---
 rtl/mem_stage_ctrl_if.sv | 31 +++
 rtl/mem_stage_ctrl.sv | 129 ++++++++++++
 tb/tb_mem_stage_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Execute-to-memory and memory-to-writeback bundle of the MEM stage.
// master = execute/write-back side, slave = mem_stage_ctrl.
interface mem_stage_ctrl_if;
  logic [31:0] ALUResIn;
  logic [31:0] STValIn;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        MEM_WB_EN;
  logic [3:0]  DestIn;
  logic        Freeze;
  logic        WB_ENOut;
  logic        MEM_R_ENOut;
  logic [31:0] ALUResOut;
  logic [31:0] MemDataOut;
  logic [3:0]  DestOut;
  logic        MemErr;

  modport master (
    output ALUResIn, STValIn, MEM_R_EN, MEM_W_EN,
    output MEM_WB_EN, DestIn,
    input  Freeze, WB_ENOut, MEM_R_ENOut, ALUResOut,
    input  MemDataOut, DestOut, MemErr
  );

  modport slave (
    input  ALUResIn, STValIn, MEM_R_EN, MEM_W_EN,
    input  MEM_WB_EN, DestIn,
    output Freeze, WB_ENOut, MEM_R_ENOut, ALUResOut,
    output MemDataOut, DestOut, MemErr
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-access stage with wait-state data memory and MEM/WB register.
// Optional range checking: define MEM_STAGE_BOUNDS_CHECK_EN.
module mem_stage_ctrl #(
  parameter int WAIT_CYCLES = 4,
  parameter int DEPTH       = 64,
  parameter int ADDR_BASE   = 1024
) (
  input logic clk,
  input logic rst_n,
  mem_stage_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nxt;
  logic           req;
  logic           freeze;
  logic [31:0]    off;
  logic [AW-1:0]  idx;
  logic           oob;
  logic           wr;
  logic [31:0]    rdata;
  logic [31:0]    mem [DEPTH];

  assign req = bus.MEM_R_EN | bus.MEM_W_EN;
  assign off = bus.ALUResIn - 32'(ADDR_BASE);
  assign idx = AW'(off >> 2);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  assign oob = (bus.ALUResIn < 32'(ADDR_BASE))
             | ((off >> 2) >= 32'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  // Read is pre-write, so a combined load/store sees the old word.
  assign rdata = oob ? 32'd0 : mem[idx];
  assign wr    = (state == DONE) & bus.MEM_W_EN & ~oob;

  // FSM state and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: IDLE -> BUSY (count down) -> DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(WAIT_CYCLES);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CW'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall upstream for the request cycle and every busy cycle.
  always_comb begin
    freeze = 1'b0;
    case (state)
      IDLE:    freeze = req;
      BUSY:    freeze = 1'b1;
      default: freeze = 1'b0;
    endcase
    freeze = freeze & rst_n;
  end

  assign bus.Freeze = freeze;

  // Data memory; no reset, so an aborted store leaves it untouched.
  always_ff @(posedge clk) begin
    if (wr) mem[idx] <= bus.STValIn;
  end

  // MEM/WB register: capture when unfrozen, otherwise insert a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.WB_ENOut    <= 1'b0;
      bus.MEM_R_ENOut <= 1'b0;
      bus.ALUResOut   <= '0;
      bus.MemDataOut  <= '0;
      bus.DestOut     <= '0;
    end else if (!freeze) begin
      bus.WB_ENOut    <= bus.MEM_WB_EN;
      bus.MEM_R_ENOut <= bus.MEM_R_EN;
      bus.ALUResOut   <= bus.ALUResIn;
      bus.MemDataOut  <= rdata;
      bus.DestOut     <= bus.DestIn;
    end else begin
      bus.WB_ENOut    <= 1'b0;
      bus.MEM_R_ENOut <= 1'b0;
    end
  end

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
  // Error pulse lines up with the completing MEM/WB capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.MemErr <= 1'b0;
    else        bus.MemErr <= (state == DONE) & oob;
  end
`else
  assign bus.MemErr = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl.
// Instance a uses 4 wait states, instance b uses none.
module tb_mem_stage_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_stage_ctrl_if ia ();
  mem_stage_ctrl_if ib ();

  mem_stage_ctrl #(.WAIT_CYCLES(4), .DEPTH(64), .ADDR_BASE(1024)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  mem_stage_ctrl #(.WAIT_CYCLES(0), .DEPTH(64), .ADDR_BASE(1024)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one instruction on instance a, count frozen cycles,
  // check bubbles, and return at the negedge after its capture edge.
  task automatic acc_a(input logic r, input logic w, input logic wb,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] dst, input int exp_n);
    int n;
    ia.MEM_R_EN = r;
    ia.MEM_W_EN = w;
    ia.MEM_WB_EN = wb;
    ia.ALUResIn = a;
    ia.STValIn = d;
    ia.DestIn = dst;
    #1;
    n = 0;
    while (ia.Freeze === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      chk("a_bubble", {30'd0, ia.WB_ENOut, ia.MEM_R_ENOut}, 32'd0);
    end
    chk("a_freeze_cycles", n, exp_n);
    @(negedge clk);
  endtask

  task automatic acc_b(input logic r, input logic w, input logic wb,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] dst, input int exp_n);
    int n;
    ib.MEM_R_EN = r;
    ib.MEM_W_EN = w;
    ib.MEM_WB_EN = wb;
    ib.ALUResIn = a;
    ib.STValIn = d;
    ib.DestIn = dst;
    #1;
    n = 0;
    while (ib.Freeze === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      chk("b_bubble", {30'd0, ib.WB_ENOut, ib.MEM_R_ENOut}, 32'd0);
    end
    chk("b_freeze_cycles", n, exp_n);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ia.MEM_R_EN = 0; ia.MEM_W_EN = 0; ia.MEM_WB_EN = 0;
    ia.ALUResIn = 0; ia.STValIn = 0; ia.DestIn = 0;
    ib.MEM_R_EN = 0; ib.MEM_W_EN = 0; ib.MEM_WB_EN = 0;
    ib.ALUResIn = 0; ib.STValIn = 0; ib.DestIn = 0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_freeze", ia.Freeze, 0);
    chk("rst_wb", ia.WB_ENOut, 0);
    chk("rst_ren", ia.MEM_R_ENOut, 0);
    chk("rst_alu", ia.ALUResOut, 0);
    chk("rst_data", ia.MemDataOut, 0);
    chk("rst_dest", ia.DestOut, 0);
    chk("rst_err", ia.MemErr, 0);
    rst_n = 1'b1;

    // ALU op passes straight through.
    acc_a(0, 0, 1, 32'h55, 0, 4'd3, 0);
    chk("add_alu", ia.ALUResOut, 32'h55);
    chk("add_dest", ia.DestOut, 3);
    chk("add_wb", ia.WB_ENOut, 1);
    chk("add_ren", ia.MEM_R_ENOut, 0);

    // Store then load, each with 4 wait states.
    acc_a(0, 1, 0, 32'd1028, 32'hDEADBEEF, 4'd0, 5);
    chk("st_wb", ia.WB_ENOut, 0);
    chk("st_alu", ia.ALUResOut, 32'd1028);
    acc_a(1, 0, 1, 32'd1028, 0, 4'd5, 5);
    chk("ld_data", ia.MemDataOut, 32'hDEADBEEF);
    chk("ld_ren", ia.MEM_R_ENOut, 1);
    chk("ld_wb", ia.WB_ENOut, 1);
    chk("ld_dest", ia.DestOut, 5);

    // Store survives a reset that aborts a later store.
    acc_a(0, 1, 0, 32'd1032, 32'h1234, 4'd0, 5);
    chk("st2_alu", ia.ALUResOut, 32'd1032);
    ia.STValIn = 32'hFFFF;
    ia.MEM_W_EN = 1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_freeze", ia.Freeze, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_freeze", ia.Freeze, 0);
    chk("mid_rst_alu", ia.ALUResOut, 0);
    chk("mid_rst_wb", ia.WB_ENOut, 0);
    chk("mid_rst_ren", ia.MEM_R_ENOut, 0);
    chk("mid_rst_dest", ia.DestOut, 0);
    ia.MEM_W_EN = 0;
    ia.MEM_R_EN = 1;
    ia.MEM_WB_EN = 1;
    ia.DestIn = 4'd7;
    @(negedge clk);
    rst_n = 1'b1;
    acc_a(1, 0, 1, 32'd1032, 0, 4'd7, 5);
    chk("ld2_data", ia.MemDataOut, 32'h1234);
    chk("ld2_dest", ia.DestOut, 7);

    // Combined load/store returns the pre-write word.
    acc_a(1, 1, 1, 32'd1032, 32'h00AB_CDEF, 4'd2, 5);
    chk("rw_old", ia.MemDataOut, 32'h1234);
    acc_a(1, 0, 1, 32'd1032, 0, 4'd2, 5);
    chk("rw_new", ia.MemDataOut, 32'h00AB_CDEF);

`ifdef MEM_STAGE_BOUNDS_CHECK_EN
    acc_a(0, 1, 0, 32'd1024, 32'h77, 4'd0, 5);
    chk("inr_err", ia.MemErr, 0);
    acc_a(0, 1, 0, 32'd1280, 32'hBAD, 4'd0, 5);
    chk("oob_st_err", ia.MemErr, 1);
    acc_a(1, 0, 1, 32'd1020, 0, 4'd1, 5);
    chk("oob_ld_err", ia.MemErr, 1);
    chk("oob_ld_data", ia.MemDataOut, 0);
    acc_a(1, 0, 1, 32'd1024, 0, 4'd1, 5);
    chk("oob_mem_kept", ia.MemDataOut, 32'h77);
    chk("oob_err_clear", ia.MemErr, 0);
`else
    acc_a(0, 1, 0, 32'd1280, 32'd9, 4'd0, 5);
    chk("wrap_err", ia.MemErr, 0);
    acc_a(1, 0, 1, 32'd1024, 0, 4'd1, 5);
    chk("wrap_data", ia.MemDataOut, 9);
`endif

    // Zero wait states: store then load back to back.
    acc_b(0, 1, 0, 32'd1024, 32'd7, 4'd0, 1);
    chk("b_st_alu", ib.ALUResOut, 32'd1024);
    acc_b(1, 0, 1, 32'd1024, 0, 4'd4, 1);
    chk("b_ld_data", ib.MemDataOut, 7);
    chk("b_ld_ren", ib.MEM_R_ENOut, 1);
    chk("b_ld_wb", ib.WB_ENOut, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
